// File: rtl/nes_alu_pkg.sv
// nes_alu_pkg: shared definitions for the 2A03-style ALU.
//   REG_WIDTH   - operand/result/status width (fixed at 8)
//   ALU_*       - operation codes driven by the instruction decoder
//   STAT_*      - bit positions inside the processor status byte {N,V,1,B,D,I,Z,C}
package nes_alu_pkg;

    localparam int REG_WIDTH = 8;

    localparam logic [7:0] ALU_NOP  = 8'h00;
    localparam logic [7:0] ALU_PASS = 8'h01;
    localparam logic [7:0] ALU_ADC  = 8'h02;
    localparam logic [7:0] ALU_SBC  = 8'h03;
    localparam logic [7:0] ALU_AND  = 8'h04;
    localparam logic [7:0] ALU_ORA  = 8'h05;
    localparam logic [7:0] ALU_EOR  = 8'h06;
    localparam logic [7:0] ALU_ASL  = 8'h07;
    localparam logic [7:0] ALU_LSR  = 8'h08;
    localparam logic [7:0] ALU_ROL  = 8'h09;
    localparam logic [7:0] ALU_ROR  = 8'h0A;
    localparam logic [7:0] ALU_INC  = 8'h0B;
    localparam logic [7:0] ALU_DEC  = 8'h0C;
    localparam logic [7:0] ALU_CMP  = 8'h0D;
    localparam logic [7:0] ALU_BIT  = 8'h0E;

    localparam int STAT_C = 0;
    localparam int STAT_Z = 1;
    localparam int STAT_I = 2;
    localparam int STAT_D = 3;
    localparam int STAT_B = 4;
    localparam int STAT_U = 5;
    localparam int STAT_V = 6;
    localparam int STAT_N = 7;

endpackage

// File: rtl/nes_alu_adder8.sv
// alu_adder8: combinational 8-bit adder with carry-in.
//   x, y  in  operands (caller pre-inverts y for subtraction)
//   cin   in  carry-in
//   sum   out x + y + cin, modulo 256
//   cout  out carry-out (no-borrow when subtracting)
//   ovf   out two's-complement overflow
module alu_adder8
    import nes_alu_pkg::*;
(
    input  logic [REG_WIDTH-1:0] x,
    input  logic [REG_WIDTH-1:0] y,
    input  logic                 cin,
    output logic [REG_WIDTH-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);

    logic [REG_WIDTH:0] full_sum;

    always_comb begin
        full_sum = {1'b0, x} + {1'b0, y} + {{REG_WIDTH{1'b0}}, cin};
        sum      = full_sum[REG_WIDTH-1:0];
        cout     = full_sum[REG_WIDTH];
        // Overflow: operands agree in sign but the sum does not.
        ovf      = (x[REG_WIDTH-1] == y[REG_WIDTH-1]) &&
                   (sum[REG_WIDTH-1] != x[REG_WIDTH-1]);
    end

endmodule

// File: rtl/nes_alu.sv
// nes_alu: 8-bit 6502-style ALU with registered result and status.
//   clk         in  system clock, rising edge
//   reset       in  asynchronous active-high reset
//   func        in  operation code (ALU_* constants)
//   a, b        in  operands
//   status_in   in  current status {N,V,1,B,D,I,Z,C}
//   dout        out registered result
//   status_out  out registered updated status
//   wout        out done strobe, high the cycle after each non-NOP op
// Arithmetic is always binary; the D flag is carried through from status_in.
module nes_alu
    import nes_alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           func,
    input  logic [REG_WIDTH-1:0] a,
    input  logic [REG_WIDTH-1:0] b,
    input  logic [REG_WIDTH-1:0] status_in,
    output logic [REG_WIDTH-1:0] dout,
    output logic [REG_WIDTH-1:0] status_out,
    output logic                 wout
);

    logic [REG_WIDTH-1:0] add_x;
    logic [REG_WIDTH-1:0] add_y;
    logic                 add_cin;
    logic [REG_WIDTH-1:0] add_sum;
    logic                 add_cout;
    logic                 add_ovf;

    logic [REG_WIDTH-1:0] result_next;
    logic [REG_WIDTH-1:0] status_next;
    logic                 valid_next;

    // Operand steering for the shared adder.
    always_comb begin
        add_x   = a;
        add_y   = b;
        add_cin = status_in[STAT_C];
        unique case (func)
            ALU_SBC: add_y = ~b;
            ALU_CMP: begin add_y = ~b;      add_cin = 1'b1; end
            ALU_INC: begin add_y = 8'h00;   add_cin = 1'b1; end
            ALU_DEC: begin add_y = 8'hFF;   add_cin = 1'b0; end
            default: ;
        endcase
    end

    alu_adder8 u_adder (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    // Result and flag selection.
    always_comb begin
        result_next         = a;
        status_next         = status_in;
        status_next[STAT_U] = 1'b1;
        valid_next          = 1'b1;
        unique case (func)
            ALU_PASS: result_next = a;
            ALU_ADC, ALU_SBC: begin
                result_next         = add_sum;
                status_next[STAT_C] = add_cout;
                status_next[STAT_V] = add_ovf;
            end
            ALU_AND: result_next = a & b;
            ALU_ORA: result_next = a | b;
            ALU_EOR: result_next = a ^ b;
            ALU_ASL: begin
                result_next         = {a[6:0], 1'b0};
                status_next[STAT_C] = a[7];
            end
            ALU_LSR: begin
                result_next         = {1'b0, a[7:1]};
                status_next[STAT_C] = a[0];
            end
            ALU_ROL: begin
                result_next         = {a[6:0], status_in[STAT_C]};
                status_next[STAT_C] = a[7];
            end
            ALU_ROR: begin
                result_next         = {status_in[STAT_C], a[7:1]};
                status_next[STAT_C] = a[0];
            end
            ALU_INC, ALU_DEC: result_next = add_sum;
            ALU_CMP: result_next = a;   // flags come from a-b below
            ALU_BIT: result_next = a;
            default: valid_next = 1'b0;
        endcase

        // N/Z: CMP reports the internal difference, BIT uses its own rules.
        if (func == ALU_CMP) begin
            status_next[STAT_C] = add_cout;
            status_next[STAT_Z] = (add_sum == 8'h00);
            status_next[STAT_N] = add_sum[7];
        end else if (func == ALU_BIT) begin
            status_next[STAT_Z] = ((a & b) == 8'h00);
            status_next[STAT_N] = b[7];
            status_next[STAT_V] = b[6];
        end else begin
            status_next[STAT_Z] = (result_next == 8'h00);
            status_next[STAT_N] = result_next[7];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout       <= 8'h00;
            status_out <= 8'h20;
            wout       <= 1'b0;
        end else begin
            wout <= valid_next;
            if (valid_next) begin
                dout       <= result_next;
                status_out <= status_next;
            end
        end
    end

endmodule

// File: tb/tb_nes_alu.sv
// tb_nes_alu: directed and randomized checks of nes_alu against an
// arithmetic reference model.
module tb_nes_alu;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] func, a, b, status_in;
    logic [7:0] dout, status_out;
    logic       wout;

    int n_vectors   = 0;
    int n_miscompare = 0;

    logic [7:0] exp_dout;
    logic [7:0] exp_status;

    always #5 clk = ~clk;

    nes_alu dut (
        .clk        (clk),
        .reset      (reset),
        .func       (func),
        .a          (a),
        .b          (b),
        .status_in  (status_in),
        .dout       (dout),
        .status_out (status_out),
        .wout       (wout)
    );

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] expv);
        n_vectors++;
        if (got !== expv) begin
            n_miscompare++;
            $display("FAIL %s: got %02h expected %02h", tag, got, expv);
        end
    endtask

    // Reference model: returns {valid, result, status}.
    function automatic logic [16:0] ref_model(input logic [7:0] f, input logic [7:0] x,
                                              input logic [7:0] y, input logic [7:0] st);
        int ia = x;
        int ib = y;
        int ci = st[0];
        int sa = (ia > 127) ? ia - 256 : ia;
        int sb = (ib > 127) ? ib - 256 : ib;
        int r  = 0;
        int sv;
        logic [7:0] s = st | 8'h20;
        logic [7:0] res = x;
        bit own_nz = 1'b0;
        bit valid  = 1'b1;
        case (f)
            8'h01: res = x;
            8'h02: begin
                r = ia + ib + ci;  res = r[7:0];  s[0] = (r > 255);
                sv = sa + sb + ci; s[6] = (sv > 127) || (sv < -128);
            end
            8'h03: begin
                r = ia - ib - (1 - ci); res = r[7:0]; s[0] = (r >= 0);
                sv = sa - sb - (1 - ci); s[6] = (sv > 127) || (sv < -128);
            end
            8'h04: res = x & y;
            8'h05: res = x | y;
            8'h06: res = x ^ y;
            8'h07: begin r = ia * 2;             res = r[7:0]; s[0] = (ia >= 128); end
            8'h08: begin r = ia / 2;             res = r[7:0]; s[0] = (ia % 2 == 1); end
            8'h09: begin r = (ia * 2 + ci) % 256; res = r[7:0]; s[0] = (ia >= 128); end
            8'h0A: begin r = ia / 2 + ci * 128;   res = r[7:0]; s[0] = (ia % 2 == 1); end
            8'h0B: begin r = (ia + 1) % 256;      res = r[7:0]; end
            8'h0C: begin r = (ia + 255) % 256;    res = r[7:0]; end
            8'h0D: begin
                own_nz = 1'b1; r = ia - ib;
                s[0] = (ia >= ib); s[1] = (ia == ib); s[7] = r[7];
            end
            8'h0E: begin
                own_nz = 1'b1;
                s[1] = ((x & y) == 8'h00); s[7] = y[7]; s[6] = y[6];
            end
            default: valid = 1'b0;
        endcase
        if (!own_nz) begin
            s[1] = (res == 8'h00);
            s[7] = res[7];
        end
        return {valid, res, s};
    endfunction

    // Drive one cycle of inputs at negedge, check 1 time unit after posedge.
    task automatic apply(input string tag, input logic [7:0] f, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] st);
        logic [16:0] m;
        @(negedge clk);
        func = f; a = x; b = y; status_in = st;
        m = ref_model(f, x, y, st);
        if (m[16]) begin
            exp_dout   = m[15:8];
            exp_status = m[7:0];
        end
        @(posedge clk);
        #1;
        check_val({tag, ".dout"},   dout,       exp_dout);
        check_val({tag, ".status"}, status_out, exp_status);
        check_val({tag, ".wout"},   {7'b0, wout}, {7'b0, m[16]});
    endtask

    initial begin
        reset = 1'b1;
        func = 8'h00; a = 8'h00; b = 8'h00; status_in = 8'h00;
        exp_dout = 8'h00; exp_status = 8'h20;
        #2;
        check_val("rst.dout",   dout,         8'h00);
        check_val("rst.status", status_out,   8'h20);
        check_val("rst.wout",   {7'b0, wout}, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases from the boundary list.
        apply("adc_ovf",  8'h02, 8'h7F, 8'h01, 8'h00);
        check_val("adc_ovf.val", dout, 8'h80);
        check_val("adc_ovf.flg", status_out, 8'hE0);
        apply("nop1",     8'h00, 8'h00, 8'h00, 8'h00);
        apply("sbc_brw",  8'h03, 8'h00, 8'h01, 8'h01);
        check_val("sbc_brw.flg", status_out, 8'hA0);
        apply("adc_wrap", 8'h02, 8'hFF, 8'h01, 8'h00);
        check_val("adc_wrap.flg", status_out, 8'h23);
        apply("ror",      8'h0A, 8'h01, 8'h00, 8'h01);
        check_val("ror.flg", status_out, 8'hA1);
        apply("asl",      8'h07, 8'h80, 8'h00, 8'h00);
        apply("cmp_eq",   8'h0D, 8'h10, 8'h10, 8'h00);
        check_val("cmp_eq.flg", status_out, 8'h23);
        apply("cmp_lt",   8'h0D, 8'h05, 8'h10, 8'h00);
        apply("bit",      8'h0E, 8'h0F, 8'hC0, 8'h00);
        check_val("bit.flg", status_out, 8'hE2);
        apply("inv",      8'hFF, 8'h12, 8'h34, 8'h0C);
        apply("nop2",     8'h00, 8'h12, 8'h34, 8'h0C);
        apply("inc_wrap", 8'h0B, 8'hFF, 8'h00, 8'h0D);
        check_val("inc_wrap.flg", status_out, 8'h2F);
        apply("held1",    8'h0C, 8'h00, 8'h00, 8'h00);
        apply("held2",    8'h0C, 8'h00, 8'h00, 8'h00);

        // Reset mid-operation, away from the clock edge.
        apply("pre_rst",  8'h05, 8'h5A, 8'h0F, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        check_val("midrst.dout",   dout,         8'h00);
        check_val("midrst.status", status_out,   8'h20);
        check_val("midrst.wout",   {7'b0, wout}, 8'h00);
        exp_dout = 8'h00; exp_status = 8'h20;
        @(negedge clk);
        func = 8'h00;
        reset = 1'b0;

        // Randomized sweep, including invalid codes and held operations.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] f;
            f = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(15, 255))
                                             : 8'($urandom_range(0, 14));
            apply("rand", f, 8'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompare);
        $finish;
    end

endmodule

// File: doc/nes_alu.md
Name: nes_alu

Overview:
- 8-bit 6502-style (2A03) arithmetic/logic unit for the CPU datapath.
- Takes two operands from the data bus plus the current STATUS register value, and an operation code from the decoder.
- Returns a registered result, an updated status byte and a one-cycle done strobe to the decoder.
- Decimal (BCD) mode is not implemented: D is carried through unchanged but never alters arithmetic.

Parameters:
- REG_WIDTH, 8, operand/result/status width (fixed at 8; parameter exists for package consistency only).

Ports:
- clk  in  1  single system clock, rising-edge active.
- reset  in  1  asynchronous, active-high reset.
- func  in  8  operation code (package constants below).
- a  in  8  operand A (accumulator / memory value).
- b  in  8  operand B (second operand).
- status_in  in  8  current processor status {N,V,1,B,D,I,Z,C}, bit7..bit0.
- dout  out  8  registered result.
- status_out  out  8  registered updated status.
- wout  out  1  done strobe, high for exactly one cycle per accepted operation.

Behaviour:
- Reset is asynchronous and active-high. While asserted: dout = 8'h00, status_out = 8'h20 (bit5 set), wout = 0.
- Operation codes:
  - 00 NOP
  - 01 PASS (A)
  - 02 ADC
  - 03 SBC
  - 04 AND
  - 05 ORA
  - 06 EOR
  - 07 ASL
  - 08 LSR
  - 09 ROL
  - 0A ROR
  - 0B INC
  - 0C DEC
  - 0D CMP
  - 0E BIT
- Any other code is treated as NOP.
- Each rising clk with a valid non-NOP func: dout <= result, status_out <= new flags, wout <= 1. Latency is one cycle.
- Each rising clk with NOP/invalid func: wout <= 0; dout and status_out hold.
- If func is held non-NOP for several cycles, the operation recomputes every cycle and wout stays high. The decoder must drop func to NOP after it sees wout.
- Arithmetic:
  - ADC: {C,r} = a + b + C_in.
  - SBC: r = a + ~b + C_in, with C = no borrow.
  - V = (a[7]==b'[7]) && (r[7]!=a[7]), where b' = b for ADC and ~b for SBC.
- Shifts and rotates operate on a:
  - ASL: C = a[7], r = a<<1.
  - LSR: C = a[0], r = a>>1.
  - ROL: r = {a[6:0],C_in}, C = a[7].
  - ROR: r = {C_in,a[7:1]}, C = a[0].
- INC/DEC: r = a±1, wrapping mod 256; C and V unchanged.
- CMP: r_internal = a - b. C = (a >= b unsigned), Z = (a == b), N = r_internal[7]. dout <= a (unchanged).
- BIT: Z = ((a & b) == 0), N = b[7], V = b[6]. dout <= a.
- Flag update summary:
  - N, Z from result for all ops except BIT (which uses the rules above).
  - V only on ADC, SBC, BIT.
  - C only on ADC, SBC, shifts/rotates, CMP.
  - Flags not updated are copied from status_in.
  - Bits 5, 4, 3, 2 (1, B, D, I) are always copied from status_in, except bit5 is forced to 1.
- Boundaries:
  - 8'hFF + 1 wraps to 00 with Z=1.
  - Signed overflow 7F+01 gives V=1.
  - Asserting reset mid-operation clears wout immediately, with no completion strobe.

Decomposition:
- Shared package holds:
  - ALU opcode constants (ALU_NOP..ALU_BIT).
  - Status bit indices (STAT_C=0, STAT_Z=1, STAT_I=2, STAT_D=3, STAT_B=4, STAT_U=5, STAT_V=6, STAT_N=7).
  - REG_WIDTH.
- One natural sub-module: alu_adder8. It is a combinational 8-bit adder with carry-in, returning sum, carry-out and overflow, and serves ADC, SBC, CMP, INC and DEC.
- Everything else (opcode decode, flag mux, output registers) lives in nes_alu.

Test Plan:
- Reset asserted mid-run -> dout=00, status_out=20, wout=0 immediately, without waiting for clk.
- ADC a=7F, b=01, C=0 -> next cycle dout=80, N=1, V=1, Z=0, C=0, wout=1 for one cycle, then 0 once func returns to NOP.
- SBC a=00, b=01, C=1 -> dout=FF, C=0, N=1, V=0; then ADC a=FF, b=01, C=0 -> dout=00, Z=1, C=1.
- ROR a=01, C=1 -> dout=80, C=1, N=1; ASL a=80 -> dout=00, C=1, Z=1.
- CMP a=10, b=10 -> Z=1, C=1, dout=10; CMP a=05, b=10 -> C=0, N=1; BIT a=0F, b=C0 -> Z=1, N=1, V=1.
- func=FF (invalid) or NOP with status_in=0C -> wout stays 0, dout/status_out hold; INC a=FF with status_in C=1 -> dout=00, Z=1, C stays 1, I/D bits preserved.
